// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor emulator: validates a Trigger pulse, waits out the burst delay,
// then drives Echo for a time proportional to the programmed distance.
module hcsr04_echo_responder #(
    parameter int unsigned TICK_DIV    = 50,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned MIN_CM      = 2,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic [8:0] distance_cm,
    input  logic       obj_present,
    output logic       echo,
    output logic       busy,
    output logic       err_short,
    output logic [7:0] echo_count
);
    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   MIN_TRIG   = 16'(MIN_TRIG_US);
    localparam logic [15:0]   BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0]   HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]   TIMEOUT    = 16'(TIMEOUT_US);
    localparam logic [15:0]   MIN_D      = 16'(MIN_CM);
    localparam logic [15:0]   MAX_D      = 16'(MAX_CM);
    localparam logic [15:0]   UPC        = 16'(US_PER_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HIGH,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t        state, state_next;
    logic          trig_meta, trig_s, trig_prev;
    logic [PW-1:0] presc;
    logic [15:0]   us_cnt;
    logic [15:0]   echo_len, echo_len_next;
    logic [15:0]   dist_wide, dist_clamped;
    logic          tick, trig_rise, trig_fall, width_ok;
    logic          echo_d, busy_d, err_d, count_inc;

    always_comb begin
        tick      = (presc == PRESC_LAST);
        trig_rise = trig_s & ~trig_prev;
        trig_fall = ~trig_s & trig_prev;
        // The tick that lands on the fall-detect cycle still counts, so a
        // Trigger of exactly MIN_TRIG_US is accepted.
        width_ok  = (us_cnt >= MIN_TRIG) || (tick && (us_cnt == MIN_TRIG - 16'd1));
        dist_wide    = {7'd0, distance_cm};
        dist_clamped = (dist_wide < MIN_D) ? MIN_D : dist_wide;
        if (!obj_present || (dist_wide > MAX_D)) begin
            echo_len_next = TIMEOUT;
        end else begin
            echo_len_next = dist_clamped * UPC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (trig_rise) state_next = TRIG_HIGH;
            TRIG_HIGH: if (trig_fall) state_next = width_ok ? BURST : IDLE;
            BURST:     if (tick && (us_cnt == BURST_LAST)) state_next = ECHO;
            ECHO:      if (tick && (us_cnt == echo_len - 16'd1)) state_next = HOLDOFF;
            HOLDOFF:   if (tick && (us_cnt == HOLD_LAST)) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state.
    always_comb begin
        echo_d    = (state_next == ECHO);
        busy_d    = (state_next != IDLE);
        err_d     = (state == TRIG_HIGH) && trig_fall && !width_ok;
        count_inc = (state == ECHO) && (state_next == HOLDOFF);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            trig_meta  <= 1'b0;
            trig_s     <= 1'b0;
            trig_prev  <= 1'b0;
            presc      <= '0;
            us_cnt     <= '0;
            echo_len   <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            err_short  <= 1'b0;
            echo_count <= '0;
        end else begin
            trig_meta <= trigger;
            trig_s    <= trig_meta;
            trig_prev <= trig_s;
            echo      <= echo_d;
            busy      <= busy_d;
            err_short <= err_d;
            if (count_inc) echo_count <= echo_count + 8'd1;
            if ((state == TRIG_HIGH) && (state_next == BURST)) echo_len <= echo_len_next;
            if (state_next != state) begin
                presc  <= '0;
                us_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick && (state != IDLE) && !((state == TRIG_HIGH) && (us_cnt >= MIN_TRIG)))
                    us_cnt <= us_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hcsr04_echo_responder.sv
// Randomized self-checking bench for hcsr04_echo_responder against a timing/arithmetic reference model.
module tb_hcsr04_echo_responder;
    localparam int unsigned TD = 4, MIN_TRIG = 10, BURST = 20, UPC = 3;
    localparam int unsigned MINCM = 2, MAXCM = 400, TMO = 1250, HOLD = 25;

    logic       clk = 1'b0, rst = 1'b0, trigger = 1'b0, obj_present = 1'b0;
    logic [8:0] distance_cm = '0;
    logic       echo, busy, err_short;
    logic [7:0] echo_count;

    int unsigned errors = 0, checks = 0, cyc = 0, err_cycles = 0, exp_count = 0;

    hcsr04_echo_responder #(
        .TICK_DIV(TD), .MIN_TRIG_US(MIN_TRIG), .BURST_US(BURST), .US_PER_CM(UPC),
        .MIN_CM(MINCM), .MAX_CM(MAXCM), .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .distance_cm(distance_cm),
        .obj_present(obj_present), .echo(echo), .busy(busy),
        .err_short(err_short), .echo_count(echo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (err_short) err_cycles <= err_cycles + 1;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Echo width in clocks derived directly from the ranging rules.
    function automatic int unsigned echo_clks(input int unsigned d, input bit obj);
        int unsigned dd;
        if (!obj || d > MAXCM) return TMO * TD;
        dd = (d < MINCM) ? MINCM : d;
        return dd * UPC * TD;
    endfunction

    task automatic pulse_trigger(input int unsigned width);
        trigger = 1'b1;
        repeat (width) step();
        trigger = 1'b0;
    endtask

    task automatic run_echo(input int unsigned d, input bit obj, input int unsigned width,
                            input bit retrig, input bit scramble);
        int unsigned exp, t0, n, w, h, err0;
        distance_cm = 9'(d);
        obj_present = obj;
        exp  = echo_clks(d, obj);
        err0 = err_cycles;
        pulse_trigger(width);
        t0 = cyc;
        n  = 0;
        while (!echo && n < BURST * TD + 50) begin
            step();
            n++;
            if (scramble && n == 5) begin
                distance_cm = 9'($urandom_range(0, 511));
                obj_present = 1'($urandom_range(0, 1));
            end
        end
        check_eq("echo_latency", cyc - t0, 2 + BURST * TD + 1);
        check_eq("busy_in_echo", 32'(busy), 1);
        w = 0;
        while (echo && w < exp + 100) begin
            step();
            w++;
            if (retrig && w == 20) trigger = 1'b1;
            if (retrig && w == 20 + MIN_TRIG * TD + 5) trigger = 1'b0;
        end
        check_eq("echo_width", w, exp);
        exp_count = (exp_count + 1) % 256;
        check_eq("echo_count", 32'(echo_count), exp_count);
        h = 0;
        while (busy && h < HOLD * TD + 50) begin
            step();
            h++;
            if (retrig && h == 5) trigger = 1'b1;
            if (retrig && h == 5 + MIN_TRIG * TD + 5) trigger = 1'b0;
        end
        check_eq("holdoff_len", h, HOLD * TD);
        repeat (3 * TD + 10) begin
            step();
            if (echo) h = 0;
        end
        check_eq("no_extra_echo", 32'(echo_count), exp_count);
        check_eq("no_err_short", err_cycles - err0, 0);
    endtask

    initial begin
        int unsigned err0, hi, n;
        rst = 1'b0;
        repeat (3) step();
        check_eq("rst_echo", 32'(echo), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_err", 32'(err_short), 0);
        check_eq("rst_count", 32'(echo_count), 0);
        rst = 1'b1;
        repeat (2) step();

        run_echo(10, 1'b1, MIN_TRIG * TD, 1'b0, 1'b0);
        run_echo(0, 1'b1, MIN_TRIG * TD + 7, 1'b0, 1'b0);
        run_echo(400, 1'b1, MIN_TRIG * TD, 1'b0, 1'b1);
        run_echo(500, 1'b1, MIN_TRIG * TD, 1'b0, 1'b0);
        run_echo(100, 1'b0, MIN_TRIG * TD, 1'b0, 1'b1);
        run_echo(30, 1'b1, MIN_TRIG * TD + 3, 1'b1, 1'b0);

        // Trigger one clock short of the minimum width must be rejected.
        err0 = err_cycles;
        distance_cm = 9'd10;
        obj_present = 1'b1;
        pulse_trigger(MIN_TRIG * TD - 1);
        hi = 0;
        repeat (BURST * TD + 40) begin
            step();
            if (echo) hi++;
        end
        check_eq("short_err_pulse", err_cycles - err0, 1);
        check_eq("short_no_echo", hi, 0);
        check_eq("short_busy", 32'(busy), 0);
        check_eq("short_count", 32'(echo_count), exp_count);

        // Reset in the middle of an Echo.
        distance_cm = 9'd50;
        pulse_trigger(MIN_TRIG * TD);
        n = 0;
        while (!echo && n < BURST * TD + 50) begin
            step();
            n++;
        end
        check_eq("pre_rst_echo", 32'(echo), 1);
        repeat (30) step();
        rst = 1'b0;
        step();
        check_eq("midrst_echo", 32'(echo), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_count", 32'(echo_count), 0);
        exp_count = 0;
        rst = 1'b1;
        repeat (3) step();
        run_echo(25, 1'b1, MIN_TRIG * TD, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            int unsigned d;
            bit obj;
            d   = ($urandom_range(0, 9) == 0) ? $urandom_range(401, 511) : $urandom_range(0, 150);
            obj = ($urandom_range(0, 7) != 0);
            run_echo(d, obj, MIN_TRIG * TD + $urandom_range(0, 30), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
